// File: rtl/window_line_buffer.sv
// window_line_buffer
// ROWS-line pixel buffer that feeds the PE array with ROWS x WIN convolution
// windows. Each write beat puts WR_W pixels into the bottom line. A shift
// moves every line up by one. A read returns a registered window that starts
// at any column, and column addressing can wrap around the line.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   flush        synchronous clear of pointers, counters and flags; pixel data is kept
//   in_valid/in_ready/in_data   write beat handshake; pixel j goes to column wr_ptr+j
//   shift        move lines up (accepted only while the bottom line is full)
//   shift_err    one-cycle pulse when a shift arrives while the bottom line is not full
//   row_full     bottom line holds COLS fresh pixels
//   win_ready    every line holds valid data
//   rd_req/rd_idx  window read request and window start column
//   rd_valid/rd_data  registered window, one cycle after rd_req; (r,k) at (r*WIN+k)*DATA_W
module window_line_buffer #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 16,
  parameter int WR_W   = 4,
  parameter int WIN    = 4,
  parameter int WRAP   = 1,
  localparam int IW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WR_W*DATA_W-1:0]     in_data,
  input  logic                       shift,
  output logic                       shift_err,
  output logic                       row_full,
  output logic                       win_ready,
  input  logic                       rd_req,
  input  logic [IW-1:0]              rd_idx,
  output logic                       rd_valid,
  output logic [ROWS*WIN*DATA_W-1:0] rd_data
);

  localparam int LW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IW:0]   COLS_C    = (IW+1)'(COLS);
  localparam logic [IW:0]   WR_W_C    = (IW+1)'(WR_W);
  localparam logic [LW-1:0] LAST_LINE = LW'(ROWS - 1);

  logic [DATA_W-1:0] line_q [ROWS][COLS];

  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW:0]   fill_cnt_q, fill_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          row_full_q, row_full_d;
  logic          shift_err_q, shift_err_d;
  logic          rd_valid_q;
  logic [ROWS*WIN*DATA_W-1:0] rd_data_q;
  logic [ROWS*WIN*DATA_W-1:0] rd_win;

  logic          accept;
  logic          do_shift;
  logic          do_write;
  logic [IW:0]   fill_sum;
  logic [IW:0]   ptr_sum;

  // A shift request blocks writes in the same cycle so that no beat is lost
  // while the lines move.
  assign in_ready = !row_full_q && !shift;
  assign accept   = in_valid && in_ready;
  assign do_shift = !flush && shift && row_full_q;
  assign do_write = !flush && accept;
  assign fill_sum = fill_cnt_q + WR_W_C;
  assign ptr_sum  = {1'b0, wr_ptr_q} + WR_W_C;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    line_cnt_d  = line_cnt_q;
    row_full_d  = row_full_q;
    shift_err_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      line_cnt_d = '0;
      row_full_d = 1'b0;
    end else if (shift) begin
      if (row_full_q) begin
        fill_cnt_d = '0;
        row_full_d = 1'b0;
        if (line_cnt_q != LAST_LINE) begin
          line_cnt_d = line_cnt_q + LW'(1);
        end
      end else begin
        shift_err_d = 1'b1;
      end
    end else if (accept) begin
      wr_ptr_d   = (ptr_sum == COLS_C) ? '0 : ptr_sum[IW-1:0];
      fill_cnt_d = fill_sum;
      row_full_d = (fill_sum == COLS_C);
    end
  end

  // Pixel storage. After a shift the bottom line keeps its old pixels; the
  // following beats overwrite them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          line_q[r][c] <= '0;
        end
      end
    end else if (do_shift) begin
      for (int r = 0; r < ROWS - 1; r++) begin
        line_q[r] <= line_q[r+1];
      end
    end else if (do_write) begin
      for (int j = 0; j < WR_W; j++) begin
        line_q[ROWS-1][wr_ptr_q + IW'(j)] <= in_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Window selection from the current (pre-update) storage. The column sum
  // carries one extra bit, so the wrap and out-of-range tests see the true value.
  for (genvar gi = 0; gi < ROWS*WIN; gi++) begin : g_elem
    localparam int R = gi / WIN;
    localparam int K = gi % WIN;
    logic [IW:0] col;
    assign col = {1'b0, rd_idx} + (IW+1)'(K);
    if (WRAP != 0) begin : g_wrap
      assign rd_win[gi*DATA_W +: DATA_W] = line_q[R][IW'(col % COLS_C)];
    end else begin : g_zero
      assign rd_win[gi*DATA_W +: DATA_W] = (col >= COLS_C) ? '0 : line_q[R][col[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      line_cnt_q  <= '0;
      row_full_q  <= 1'b0;
      shift_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      line_cnt_q  <= line_cnt_d;
      row_full_q  <= row_full_d;
      shift_err_q <= shift_err_d;
      rd_valid_q  <= rd_req && !flush;
      // rd_data holds its value whenever no read is returned.
      if (rd_req && !flush) begin
        rd_data_q <= rd_win;
      end
    end
  end

  assign row_full  = row_full_q;
  assign win_ready = row_full_q && (line_cnt_q == LAST_LINE);
  assign shift_err = shift_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Testbench for window_line_buffer. Two instances with the same inputs are
// driven together: one with column wrap enabled and one with it disabled.
// Expected windows come from a behavioural line model and are queued when a
// read is requested. They are popped when rd_valid is seen.
module tb_window_line_buffer;

  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 16;
  localparam int WRW  = 4;
  localparam int WIN  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         shift = 1'b0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_idx = '0;

  logic         in_ready, shift_err, row_full, win_ready, rd_valid;
  logic [127:0] rd_data;
  logic         in_ready0, shift_err0, row_full0, win_ready0, rd_valid0;
  logic [127:0] rd_data0;

  window_line_buffer #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .WR_W(WRW), .WIN(WIN), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift(shift), .shift_err(shift_err), .row_full(row_full),
    .win_ready(win_ready), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  window_line_buffer #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .WR_W(WRW), .WIN(WIN), .WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .shift(shift), .shift_err(shift_err0), .row_full(row_full0),
    .win_ready(win_ready0), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid0), .rd_data(rd_data0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w1;
    logic [127:0] w0;
    int           idx;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] m_line [ROWS][COLS];
  int         m_wr, m_fill, m_lcnt;
  bit         m_full, m_err;
  logic [127:0] last1, last0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_line[r][c] = 8'h00;
    m_wr = 0; m_fill = 0; m_lcnt = 0; m_full = 0; m_err = 0;
    last1 = '0; last0 = '0;
    exp_q.delete();
  endtask

  function automatic logic [127:0] model_win(input int idx, input bit wrap);
    logic [127:0] w;
    int c;
    logic [7:0] px;
    w = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < WIN; k++) begin
        c = idx + k;
        if (c >= COLS) px = wrap ? m_line[r][c-COLS] : 8'h00;
        else           px = m_line[r][c];
        w[(r*WIN+k)*DW +: DW] = px;
      end
    end
    return w;
  endfunction

  // Beat b of a line whose pixel c is 0x10*L + c.
  function automatic logic [31:0] beat(input int L, input int b);
    logic [31:0] w;
    for (int j = 0; j < WRW; j++) w[j*DW +: DW] = 8'(16*L + 4*b + j);
    return w;
  endfunction

  // One clock cycle: drive at edge+1, check in_ready, step the model at the
  // edge, then check flags and any returned window at edge+1.
  task automatic step(input bit v, input logic [31:0] d, input bit sh, input bit rq, input int idx, input bit fl);
    exp_t e;
    logic [3:0] exp_flags;
    in_valid = v; in_data = d; shift = sh; rd_req = rq; rd_idx = 4'(idx); flush = fl;
    if (rq && !fl) begin
      e.w1 = model_win(idx, 1'b1);
      e.w0 = model_win(idx, 1'b0);
      e.idx = idx;
      exp_q.push_back(e);
    end
    #1;
    check_eq("in_ready", 128'({in_ready, in_ready0}), 128'({2{!m_full && !sh}}));
    @(posedge clk);
    m_err = 0;
    if (fl) begin
      m_wr = 0; m_fill = 0; m_lcnt = 0; m_full = 0;
    end else if (sh) begin
      if (m_full) begin
        for (int r = 0; r < ROWS-1; r++) m_line[r] = m_line[r+1];
        m_fill = 0; m_full = 0;
        if (m_lcnt < ROWS-1) m_lcnt++;
      end else begin
        m_err = 1;
      end
    end else if (v && !m_full) begin
      for (int j = 0; j < WRW; j++) m_line[ROWS-1][m_wr+j] = d[j*DW +: DW];
      m_wr = (m_wr + WRW) % COLS;
      m_fill += WRW;
      m_full = (m_fill == COLS);
    end
    #1;
    in_valid = 1'b0; shift = 1'b0; rd_req = 1'b0; flush = 1'b0;
    exp_flags = {m_full, m_full && (m_lcnt == ROWS-1), m_err, rq && !fl};
    check_eq("flags_wrap", 128'({row_full, win_ready, shift_err, rd_valid}), 128'(exp_flags));
    check_eq("flags_nowrap", 128'({row_full0, win_ready0, shift_err0, rd_valid0}), 128'(exp_flags));
    if (rd_valid) begin
      check_eq("rd_queue_nonempty", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("rd_data_wrap", rd_data, e.w1);
        check_eq("rd_data_nowrap", rd_data0, e.w0);
        last1 = e.w1; last0 = e.w0;
        $display("read idx=%0d wrap=%h nowrap=%h", e.idx, rd_data, rd_data0);
      end
    end else begin
      check_eq("rd_hold", rd_data, last1);
      check_eq("rd_hold_nowrap", rd_data0, last0);
    end
  endtask

  task automatic fill_line(input int L);
    for (int b = 0; b < COLS/WRW; b++) step(1'b1, beat(L, b), 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_in_ready", 128'(in_ready), 128'(1));
    check_eq("reset_flags", 128'({row_full, win_ready, rd_valid, shift_err}), 128'(0));
    check_eq("reset_rd_data", rd_data, 128'(0));

    // First line: pixel c = c, then a stalled fifth beat.
    fill_line(0);
    check_eq("row_full_after_4", 128'(row_full), 128'(1));
    step(1'b1, beat(9, 0), 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 0, 1'b0);
    check_eq("line3_first4", 128'(rd_data[127:96]), 128'(32'h03020100));

    // Build lines so that line r pixel c = 0x10*r + c.
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    for (int L = 1; L < ROWS; L++) begin
      fill_line(L);
      if (L < ROWS-1) step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    end
    check_eq("win_ready_set", 128'(win_ready), 128'(1));
    step(1'b0, '0, 1'b0, 1'b1, 2, 1'b0);
    check_eq("elem_3_3", 128'(rd_data[127:120]), 128'(8'h35));
    check_eq("elem_0_0", 128'(rd_data[7:0]), 128'(8'h02));
    step(1'b0, '0, 1'b0, 1'b1, 14, 1'b0);
    check_eq("wrap_row0", 128'(rd_data[31:0]), 128'(32'h01000F0E));
    check_eq("nowrap_row0", 128'(rd_data0[31:0]), 128'(32'h00000F0E));

    // Valid shift, then an illegal shift with the bottom line not full.
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("shift_err_pulse", 128'(shift_err), 128'(1));
    step(1'b0, '0, 1'b0, 1'b1, 5, 1'b0);
    check_eq("shift_err_cleared", 128'(shift_err), 128'(0));

    // Refill: line_cnt stayed saturated, so win_ready comes straight back.
    fill_line(4);
    check_eq("win_ready_refill", 128'(win_ready), 128'(1));
    // Shift together with a beat: the beat waits one cycle and lands at column 0.
    step(1'b1, beat(5, 0), 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, beat(5, 0), 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 0, 1'b0);
    check_eq("post_shift_beat", 128'(rd_data[127:96]), 128'(32'h53525150));
    step(1'b0, '0, 1'b0, 1'b1, 12, 1'b0);

    // Flush mid-line, with a read in the same cycle that must not return.
    step(1'b1, beat(5, 1), 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 0, 1'b1);
    fill_line(6);
    check_eq("win_ready_after_flush", 128'(win_ready), 128'(0));

    // Random window reads over the stored data.
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b1, int'($urandom_range(0, 15)), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of the third beat of a line.
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, beat(7, 0), 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, beat(7, 1), 1'b0, 1'b0, 0, 1'b0);
    in_valid = 1'b1; in_data = beat(7, 2); rd_req = 1'b1; rd_idx = 4'd3;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_flags", 128'({row_full, win_ready, rd_valid, shift_err}), 128'(0));
    check_eq("async_rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("async_rst_rd_data", rd_data, 128'(0));
    model_reset();
    @(negedge clk);
    in_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, '0, 1'b0, 1'b1, 4, 1'b0);
    for (int b = 0; b < 3; b++) step(1'b1, beat(8, b), 1'b0, 1'b0, 0, 1'b0);
    check_eq("refill_not_full_at_3", 128'(row_full), 128'(0));
    step(1'b1, beat(8, 3), 1'b0, 1'b0, 0, 1'b0);
    check_eq("refill_full_at_4", 128'(row_full), 128'(1));
    step(1'b0, '0, 1'b0, 1'b1, 13, 1'b0);

    check_eq("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised successor to the fixed 4x16 CNN input window buffer.
- Stores ROWS lines of COLS pixels. Input words are streamed into the bottom line through a valid/ready handshake, and a shift moves lines up.
- Serves registered ROWSxWIN convolution windows at any column start, with optional circular addressing.
- Sits between the input-feature memory reader and the PE array window register.

Parameters:
DATA_W, 8, pixel width in bits
ROWS, 4, number of lines (kernel height)
COLS, 16, pixels per line; must be a multiple of WR_W
WR_W, 4, pixels accepted per write beat
WIN, 4, window width in pixels; WIN <= COLS
WRAP, 1, 1 = column index wraps modulo COLS; 0 = columns >= COLS read as 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers and counters; buffer data is kept
in_valid  in  1  write beat valid
in_ready  out  1  buffer can accept a beat
in_data  in  WR_W*DATA_W  pixel j at [j*DATA_W +: DATA_W], written to column wr_ptr+j
shift  in  1  move every line up by one
shift_err  out  1  one-cycle pulse: shift requested while bottom line not full
row_full  out  1  bottom line holds COLS fresh pixels
win_ready  out  1  all ROWS lines hold valid data
rd_req  in  1  window read request
rd_idx  in  clog2(COLS)  window start column
rd_valid  out  1  rd_data valid
rd_data  out  ROWS*WIN*DATA_W  element (r,k) at [(r*WIN+k)*DATA_W +: DATA_W]; r=0 is the top line

Behaviour:
- Reset (rst_n=0, asynchronous): all storage = 0; wr_ptr = 0; fill_cnt = 0; line_cnt = 0; in_ready = 1; row_full = 0; win_ready = 0; rd_valid = 0; rd_data = 0; shift_err = 0.
- Reset asserted mid-beat or mid-read aborts that operation with no partial write.
- in_ready = !row_full && !shift (combinational). A beat is accepted when in_valid && in_ready.
- Accept:
  - line[ROWS-1][wr_ptr+j] <= in_data pixel j, for j = 0..WR_W-1.
  - wr_ptr += WR_W; fill_cnt += WR_W.
  - row_full = (fill_cnt == COLS), registered.
  - wr_ptr wraps to 0 after the last beat of a line.
- Beats offered while row_full = 1 are not accepted. Data is held upstream, never dropped.
- Shift with row_full = 1, in the following cycle:
  - line[r] <= line[r+1] for r = 0..ROWS-2.
  - The bottom line keeps its old contents, which are overwritten by later beats.
  - fill_cnt = 0; row_full = 0; line_cnt = min(line_cnt+1, ROWS-1).
- Shift with row_full = 0: no change to storage or counters; shift_err = 1 for exactly one cycle.
- shift has priority over a write in the same cycle. in_ready is low, so no beat is lost.
- win_ready = row_full && (line_cnt == ROWS-1).
- Read: rd_req sampled at edge N gives rd_valid = 1 and rd_data at edge N+1 (1-cycle latency).
  - rd_valid = 0 the cycle after a cycle without rd_req.
  - rd_data holds its last value while rd_valid = 0.
  - Element (r,k) = line[r][c], where c = rd_idx+k.
  - WRAP=1: c is taken mod COLS.
  - WRAP=0: the element is 0 when c >= COLS.
- Read in the same cycle as a write or shift returns pre-update contents. No bypass.
- Reads are permitted while win_ready = 0 and return whatever data is stored.
- flush: wr_ptr, fill_cnt and line_cnt return to 0; row_full, win_ready and shift_err return to 0; rd_valid = 0 next cycle. flush overrides shift and write in the same cycle.
- Widths: rd_idx+k is computed at clog2(COLS)+1 bits before the wrap or zero test. No arithmetic is done on the pixel data.

Test Plan:
- Reset release, defaults: in_ready = 1, row_full = 0, win_ready = 0, rd_valid = 0, rd_data = 0.
- Four beats {0x03,0x02,0x01,0x00}, {0x07..0x04}, {0x0B..0x08}, {0x0F..0x0C} (pixel 0 in the low byte) -> row_full = 1 after the 4th beat; a 5th beat is stalled with in_ready = 0; line[3][c] = c.
- Fill and shift ROWS times, with line L pixel c = 0x10*L+c, leaving the 4th fill unshifted -> win_ready = 1. rd_req with rd_idx = 2 -> one cycle later rd_valid = 1, element (r,k) = 0x10*r+2+k, e.g. (3,3) = 0x35.
- WRAP=1, rd_idx = 14 -> row-0 elements = 0x0E, 0x0F, 0x00, 0x01. Rebuild with WRAP=0, same read -> 0x0E, 0x0F, 0x00, 0x00.
- shift with row_full = 0 -> shift_err pulses for 1 cycle; storage and line_cnt unchanged. shift together with in_valid while row_full = 1 -> shift applied, beat accepted only in the next cycle at wr_ptr = 0.
- rst_n dropped asynchronously in the middle of the third beat of a line -> all outputs 0 immediately. After release, refill shows fill_cnt restarted at 0 (row_full only after 4 new beats).
